// File: rtl/fft_ctrl_pkg.sv
// Shared FSM encoding and sizing helpers for the radix-2 DIT FFT butterfly sequencer.
package fft_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

    localparam int DEFAULT_LOG2_PTS = 3;
    localparam int PTS              = 1 << DEFAULT_LOG2_PTS;
    localparam int HALF_PTS         = PTS / 2;

    // Width of the stage counter; never narrower than one bit.
    function automatic int stage_width(input int log2_pts);
        return (log2_pts <= 2) ? 1 : $clog2(log2_pts);
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational map from (stage, butterfly) to the point pair and twiddle index of
// an in-place radix-2 DIT butterfly.
module fft_addr_gen
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2_PTS = DEFAULT_LOG2_PTS,
    parameter int SW       = stage_width(LOG2_PTS)
) (
    input  logic [SW-1:0]       stage_i,
    input  logic [LOG2_PTS-2:0] bfly_i,
    output logic [LOG2_PTS-1:0] addr0_o,
    output logic [LOG2_PTS-1:0] addr1_o,
    output logic [LOG2_PTS-2:0] tw_addr_o
);

    localparam int BW = LOG2_PTS - 1;
    localparam logic [LOG2_PTS-1:0] ONE = LOG2_PTS'(1);

    logic [LOG2_PTS-1:0] b_ext_s;
    logic [LOG2_PTS-1:0] half_s;
    logic [LOG2_PTS-1:0] pos_s;
    logic [LOG2_PTS-1:0] grp_s;
    logic [LOG2_PTS-1:0] addr0_s;

    // The group index is shifted back up one extra bit to skip over the lower halves.
    always_comb begin
        b_ext_s   = {1'b0, bfly_i};
        half_s    = ONE << stage_i;
        pos_s     = b_ext_s & (half_s - ONE);
        grp_s     = b_ext_s >> stage_i;
        addr0_s   = ((grp_s << stage_i) << 1'b1) | pos_s;
        addr0_o   = addr0_s;
        addr1_o   = addr0_s | half_s;
        tw_addr_o = BW'(pos_s << (LOG2_PTS - 1 - int'(stage_i)));
    end

endmodule

// File: rtl/fft_bfly_sched.sv
// Sequencer stepping every butterfly of an in-place radix-2 FFT through one shared
// butterfly unit: READ, WAIT, RUN (until bf_done or watchdog), WRITE.
module fft_bfly_sched
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2_PTS = DEFAULT_LOG2_PTS,
    parameter int TIMEOUT  = 15
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                go_i,
    input  logic                                bf_done_i,
    output logic                                bf_start_o,
    output logic                                rd_en_o,
    output logic                                wr_en_o,
    output logic                                bank_o,
    output logic [LOG2_PTS-1:0]                 addr0_o,
    output logic [LOG2_PTS-1:0]                 addr1_o,
    output logic [LOG2_PTS-2:0]                 tw_addr_o,
    output logic [stage_width(LOG2_PTS)-1:0]    stage_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                err_o
);

    localparam int SW  = stage_width(LOG2_PTS);
    localparam int BW  = LOG2_PTS - 1;
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0]  LAST_B  = {BW{1'b1}};
    localparam logic [SW-1:0]  LAST_S  = SW'(LOG2_PTS - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [SW-1:0]       s_q, s_d, stage_q, stage_d;
    logic [BW-1:0]       b_q, b_d, tw_q, tw_d, ag_tw_s;
    logic [WDW-1:0]      wdog_q, wdog_d;
    logic [LOG2_PTS-1:0] addr0_q, addr0_d, addr1_q, addr1_d, ag_addr0_s, ag_addr1_s;
    logic bf_start_q, bf_start_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d, bank_q, bank_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d, load_s;

    fft_addr_gen #(.LOG2_PTS(LOG2_PTS), .SW(SW)) u_addr_gen (
        .stage_i   (s_d),
        .bfly_i    (b_d),
        .addr0_o   (ag_addr0_s),
        .addr1_o   (ag_addr1_s),
        .tw_addr_o (ag_tw_s)
    );

    // FSM transitions, butterfly/stage counters, watchdog and strobes.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        b_d     = b_q;
        wdog_d  = wdog_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (go_i) begin
                    err_d   = 1'b0;
                    s_d     = '0;
                    b_d     = '0;
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
                wdog_d  = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bf_done_i) begin
                    state_d = ST_WRITE;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            ST_WRITE: begin
                if (b_q != LAST_B) begin
                    b_d     = b_q + BW'(1);
                    state_d = ST_READ;
                end else if (s_q != LAST_S) begin
                    b_d     = '0;
                    s_d     = s_q + SW'(1);
                    state_d = ST_READ;
                end else begin
                    b_d     = '0;
                    s_d     = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Strobes follow the next state so every output comes straight from a flop.
        rd_en_d    = (state_d == ST_READ);
        wr_en_d    = (state_d == ST_WRITE);
        bf_start_d = (state_d == ST_RUN);
        busy_d     = (state_d != ST_IDLE);
        load_s     = rd_en_d;
    end

    // Address, twiddle and bank are captured on entry to READ and held through WRITE.
    always_comb begin
        if (load_s) begin
            addr0_d = ag_addr0_s;
            addr1_d = ag_addr1_s;
            tw_d    = ag_tw_s;
            stage_d = s_d;
            bank_d  = s_d[0];
        end else begin
            addr0_d = addr0_q;
            addr1_d = addr1_q;
            tw_d    = tw_q;
            stage_d = stage_q;
            bank_d  = bank_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            b_q        <= '0;
            wdog_q     <= '0;
            bf_start_q <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            bank_q     <= 1'b0;
            addr0_q    <= '0;
            addr1_q    <= '0;
            tw_q       <= '0;
            stage_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            b_q        <= b_d;
            wdog_q     <= wdog_d;
            bf_start_q <= bf_start_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            bank_q     <= bank_d;
            addr0_q    <= addr0_d;
            addr1_q    <= addr1_d;
            tw_q       <= tw_d;
            stage_q    <= stage_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bf_start_o = bf_start_q;
    assign rd_en_o    = rd_en_q;
    assign wr_en_o    = wr_en_q;
    assign bank_o     = bank_q;
    assign addr0_o    = addr0_q;
    assign addr1_o    = addr1_q;
    assign tw_addr_o  = tw_q;
    assign stage_o    = stage_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched: 8-point and 4-point instances driven by a butterfly
// model with per-butterfly latency, checked against a textbook FFT loop model.
module tb_fft_bfly_sched;

    typedef struct { int a0; int a1; int tw; int bank; } ent_t;
    typedef struct { int a0; int a1; int tw; int bank; int ra0; int ra1; int rtw; int rbank; } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, go_r = 1'b0, bfd = 1'b0, sel = 1'b0;
    bit   noise_en = 1'b0;
    int   k_q[$];
    int   run_cnt = 0, k_cur = 8;
    ent_t exp_q[$];
    obs_t obs_q[$];
    int   n_cmp = 0, n_bad = 0;

    logic d8_bs, d8_rd, d8_wr, d8_bank, d8_busy, d8_done, d8_err;
    logic [2:0] d8_a0, d8_a1;
    logic [1:0] d8_tw, d8_stage;
    logic d4_bs, d4_rd, d4_wr, d4_bank, d4_busy, d4_done, d4_err;
    logic [1:0] d4_a0, d4_a1;
    logic [0:0] d4_tw, d4_stage;

    fft_bfly_sched #(.LOG2_PTS(3), .TIMEOUT(15)) dut8 (
        .clk_i(clk), .rst_i(rst), .go_i(go_r & ~sel), .bf_done_i(bfd & ~sel),
        .bf_start_o(d8_bs), .rd_en_o(d8_rd), .wr_en_o(d8_wr), .bank_o(d8_bank),
        .addr0_o(d8_a0), .addr1_o(d8_a1), .tw_addr_o(d8_tw), .stage_o(d8_stage),
        .busy_o(d8_busy), .done_o(d8_done), .err_o(d8_err));

    fft_bfly_sched #(.LOG2_PTS(2), .TIMEOUT(15)) dut4 (
        .clk_i(clk), .rst_i(rst), .go_i(go_r & sel), .bf_done_i(bfd & sel),
        .bf_start_o(d4_bs), .rd_en_o(d4_rd), .wr_en_o(d4_wr), .bank_o(d4_bank),
        .addr0_o(d4_a0), .addr1_o(d4_a1), .tw_addr_o(d4_tw), .stage_o(d4_stage),
        .busy_o(d4_busy), .done_o(d4_done), .err_o(d4_err));

    logic o_bs, o_rd, o_wr, o_bank, o_busy, o_done, o_err;
    logic [2:0] o_a0, o_a1;
    logic [1:0] o_tw, o_stage;
    assign o_bs    = sel ? d4_bs : d8_bs;
    assign o_rd    = sel ? d4_rd : d8_rd;
    assign o_wr    = sel ? d4_wr : d8_wr;
    assign o_bank  = sel ? d4_bank : d8_bank;
    assign o_busy  = sel ? d4_busy : d8_busy;
    assign o_done  = sel ? d4_done : d8_done;
    assign o_err   = sel ? d4_err : d8_err;
    assign o_a0    = sel ? {1'b0, d4_a0} : d8_a0;
    assign o_a1    = sel ? {1'b0, d4_a1} : d8_a1;
    assign o_tw    = sel ? {1'b0, d4_tw} : d8_tw;
    assign o_stage = sel ? {1'b0, d4_stage} : d8_stage;

    // Butterfly model: bf_done high in the k-th cycle of bf_start (k=0 never answers).
    always @(negedge clk) begin
        if (o_bs) begin
            run_cnt = run_cnt + 1;
            if (run_cnt == 1) k_cur = (k_q.size() > 0) ? k_q.pop_front() : 8;
            bfd = (k_cur != 0) && (run_cnt == k_cur);
        end else begin
            run_cnt = 0;
            bfd = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Textbook in-place DIT loop: groups of 2*half, twiddle k*(N/2)/half.
    function automatic void build_expected(input int l2);
        int n = 1 << l2;
        exp_q.delete();
        for (int s = 0; s < l2; s++) begin
            int half = 1 << s;
            for (int j = 0; j < n; j += 2 * half)
                for (int k = 0; k < half; k++) begin
                    ent_t e;
                    e.a0 = j + k; e.a1 = j + k + half; e.tw = k * (n / 2) / half; e.bank = s % 2;
                    exp_q.push_back(e);
                end
        end
    endfunction

    // Records the address tuple at each read and write strobe plus done timing.
    task automatic collect(input int max_cyc, input int spam_until,
                           output int done_cyc, output int n_done, output int n_wr);
        obs_t ob;
        int ra0 = 0, ra1 = 0, rtw = 0, rbank = 0, tail_end = max_cyc;
        done_cyc = -1; n_done = 0; n_wr = 0; obs_q.delete();
        for (int cyc = 1; cyc <= tail_end; cyc++) begin
            @(negedge clk);
            if (o_rd) begin ra0 = int'(o_a0); ra1 = int'(o_a1); rtw = int'(o_tw); rbank = int'(o_bank); end
            if (o_wr) begin
                ob.a0 = int'(o_a0); ob.a1 = int'(o_a1); ob.tw = int'(o_tw); ob.bank = int'(o_bank);
                ob.ra0 = ra0; ob.ra1 = ra1; ob.rtw = rtw; ob.rbank = rbank;
                obs_q.push_back(ob); n_wr++;
            end
            if (o_done) begin
                n_done++;
                if (done_cyc < 0) begin done_cyc = cyc; tail_end = cyc + 2; end
            end
            go_r = (cyc < spam_until) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        go_r = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; go_r = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({d8_bs, d8_rd, d8_wr, d8_bank, d8_a0, d8_a1, d8_tw, d8_stage, d8_busy, d8_done, d8_err} !== '0) begin
            n_bad++; $display("FAIL reset8: outputs not all zero (a0=%0d a1=%0d busy=%b)", d8_a0, d8_a1, d8_busy);
        end
        n_cmp++;
        if ({d4_bs, d4_rd, d4_wr, d4_bank, d4_a0, d4_a1, d4_tw, d4_stage, d4_busy, d4_done, d4_err} !== '0) begin
            n_bad++; $display("FAIL reset4: outputs not all zero (a0=%0d a1=%0d busy=%b)", d4_a0, d4_a1, d4_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_frame8();
        int dc, nd, nw;
        sel = 1'b0; build_expected(3);
        start_frame();
        collect(400, 0, dc, nd, nw);
        n_cmp++; if (nw !== 12) begin n_bad++; $display("FAIL frame8_writes: got %0d want 12", nw); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if ({obs_q[i].a0, obs_q[i].a1, obs_q[i].tw, obs_q[i].bank} !== {exp_q[i].a0, exp_q[i].a1, exp_q[i].tw, exp_q[i].bank}) begin
                n_bad++; $display("FAIL frame8_addr[%0d]: got (%0d,%0d) tw=%0d bank=%0d want (%0d,%0d) tw=%0d bank=%0d", i,
                    obs_q[i].a0, obs_q[i].a1, obs_q[i].tw, obs_q[i].bank, exp_q[i].a0, exp_q[i].a1, exp_q[i].tw, exp_q[i].bank);
            end
            n_cmp++;
            if ({obs_q[i].ra0, obs_q[i].ra1, obs_q[i].rtw, obs_q[i].rbank} !== {obs_q[i].a0, obs_q[i].a1, obs_q[i].tw, obs_q[i].bank}) begin
                n_bad++; $display("FAIL frame8_stable[%0d]: read (%0d,%0d) write (%0d,%0d)", i, obs_q[i].ra0, obs_q[i].ra1, obs_q[i].a0, obs_q[i].a1);
            end
        end
        n_cmp++; if (dc !== 133) begin n_bad++; $display("FAIL frame8_done_cycle: got %0d want 133", dc); end
        n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL frame8_done_pulses: got %0d want 1", nd); end
        n_cmp++; if ({o_err, o_busy} !== 2'b00) begin n_bad++; $display("FAIL frame8_idle: err=%b busy=%b want 0 0", o_err, o_busy); end
    endtask

    task automatic test_random_k();
        int dc, nd, nw, exp_dc;
        sel = 1'b0; noise_en = 1'b1; build_expected(3);
        for (int it = 0; it < 3; it++) begin
            exp_dc = 1;
            k_q.delete();
            for (int b = 0; b < 12; b++) begin
                int k = $urandom_range(1, 12);
                k_q.push_back(k);
                exp_dc += k + 3;
            end
            start_frame();
            collect(400, exp_dc, dc, nd, nw);
            n_cmp++; if (dc !== exp_dc) begin n_bad++; $display("FAIL rand_done_cycle[%0d]: got %0d want %0d", it, dc, exp_dc); end
            n_cmp++; if ({nw, nd} !== {32'sd12, 32'sd1}) begin n_bad++; $display("FAIL rand_counts[%0d]: writes %0d dones %0d want 12 1", it, nw, nd); end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if ({obs_q[i].a0, obs_q[i].a1, obs_q[i].tw, obs_q[i].bank, obs_q[i].ra0, obs_q[i].ra1}
                    !== {exp_q[i].a0, exp_q[i].a1, exp_q[i].tw, exp_q[i].bank, exp_q[i].a0, exp_q[i].a1}) begin
                    n_bad++; $display("FAIL rand_addr[%0d.%0d]: got (%0d,%0d) tw=%0d read (%0d,%0d) want (%0d,%0d) tw=%0d", it, i,
                        obs_q[i].a0, obs_q[i].a1, obs_q[i].tw, obs_q[i].ra0, obs_q[i].ra1, exp_q[i].a0, exp_q[i].a1, exp_q[i].tw);
                end
            end
        end
        noise_en = 1'b0; k_q.delete();
    endtask

    task automatic test_timeout();
        int dc, nd, nw;
        sel = 1'b0; k_q.delete();
        k_q.push_back(8); k_q.push_back(8); k_q.push_back(0);
        start_frame();
        collect(200, 0, dc, nd, nw);
        n_cmp++; if (dc !== 40) begin n_bad++; $display("FAIL timeout_done_cycle: got %0d want 40", dc); end
        n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL timeout_done_pulses: got %0d want 1", nd); end
        n_cmp++; if (nw !== 2) begin n_bad++; $display("FAIL timeout_writes: got %0d want 2", nw); end
        n_cmp++; if ({o_err, o_busy} !== 2'b10) begin n_bad++; $display("FAIL timeout_err: err=%b busy=%b want 1 0", o_err, o_busy); end
        start_frame();
        @(negedge clk);
        go_r = 1'b0;
        n_cmp++; if ({o_err, o_busy, o_rd} !== 3'b011) begin n_bad++; $display("FAIL timeout_err_clear: err=%b busy=%b rd=%b want 0 1 1", o_err, o_busy, o_rd); end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset_run();
        bit found = 1'b0;
        sel = 1'b0;
        start_frame();
        @(negedge clk); go_r = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (o_bs && o_stage == 2'd1) found = 1'b1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rstrun_reach: stage 1 RUN not seen, stage=%0d", o_stage); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({o_bs, o_rd, o_wr, o_bank, o_a0, o_a1, o_tw, o_stage, o_busy, o_done, o_err} !== '0) begin
            n_bad++; $display("FAIL rstrun_zero: bs=%b busy=%b a0=%0d a1=%0d stage=%0d want all 0", o_bs, o_busy, o_a0, o_a1, o_stage);
        end
        rst = 1'b0; go_r = 1'b1;
        @(negedge clk);
        go_r = 1'b0;
        n_cmp++;
        if ({o_rd, o_a0, o_a1, o_tw, o_stage, o_bank} !== {1'b1, 3'd0, 3'd1, 2'd0, 2'd0, 1'b0}) begin
            n_bad++; $display("FAIL rstrun_restart: rd=%b a0=%0d a1=%0d tw=%0d stage=%0d want 1 0 1 0 0", o_rd, o_a0, o_a1, o_tw, o_stage);
        end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int dc = -1;
        sel = 1'b0; k_q.delete();
        start_frame();
        for (int cyc = 1; cyc <= 200 && dc < 0; cyc++) begin
            @(negedge clk);
            if (o_done) dc = cyc;
            go_r = (cyc >= 130) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        n_cmp++; if (dc !== 133) begin n_bad++; $display("FAIL b2b_done_cycle: got %0d want 133", dc); end
        @(negedge clk);
        go_r = 1'b0;
        n_cmp++;
        if ({o_rd, o_a0, o_a1, o_busy} !== {1'b1, 3'd0, 3'd1, 1'b1}) begin
            n_bad++; $display("FAIL b2b_restart: rd=%b a0=%0d a1=%0d busy=%b want 1 0 1 1", o_rd, o_a0, o_a1, o_busy);
        end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_points4();
        int dc, nd, nw;
        sel = 1'b1; k_q.delete(); build_expected(2);
        @(negedge clk);
        start_frame();
        collect(200, 0, dc, nd, nw);
        n_cmp++; if (nw !== 4) begin n_bad++; $display("FAIL pts4_writes: got %0d want 4", nw); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if ({obs_q[i].a0, obs_q[i].a1, obs_q[i].tw, obs_q[i].bank} !== {exp_q[i].a0, exp_q[i].a1, exp_q[i].tw, exp_q[i].bank}) begin
                n_bad++; $display("FAIL pts4_addr[%0d]: got (%0d,%0d) tw=%0d bank=%0d want (%0d,%0d) tw=%0d bank=%0d", i,
                    obs_q[i].a0, obs_q[i].a1, obs_q[i].tw, obs_q[i].bank, exp_q[i].a0, exp_q[i].a1, exp_q[i].tw, exp_q[i].bank);
            end
        end
        n_cmp++; if (dc !== 45) begin n_bad++; $display("FAIL pts4_done_cycle: got %0d want 45", dc); end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame8();
        test_random_k();
        test_timeout();
        test_reset_run();
        test_back_to_back();
        test_points4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL tb_watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
